// File: rtl/cnt2bcd_pkg.sv
// -----------------------------------------------------------------------------
// cnt2bcd_pkg
//   Shared types and constants for the cnt2bcd binary-to-BCD converter.
//   - cnt2bcd_state_t : converter FSM states (IDLE, CONV)
//   - bcd_digit_t     : one packed BCD digit
//   - BCD_ADD_THRESH  : digit value at or above which shift-and-add-3 corrects
//   - BCD_ADD_VAL     : correction added to such a digit before the shift
// -----------------------------------------------------------------------------
package cnt2bcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } cnt2bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADD_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADD_VAL    = 4'd3;

endpackage

// File: rtl/cnt2bcd_if.sv
// -----------------------------------------------------------------------------
// cnt2bcd_if
//   Handshake/data bundle between a requester and the cnt2bcd converter.
//   Parameters IN_W / DIGITS must match the converter instance.
//   Signals:
//     start_i  requester -> converter  conversion request
//     bin_i    requester -> converter  binary value captured with start_i
//     busy_o   converter -> requester  conversion in progress
//     done_o   converter -> requester  1-cycle pulse, bcd_o new and valid
//     bcd_o    converter -> requester  packed BCD, digit 0 in [3:0]
//     blank_o  converter -> requester  leading-zero blank mask
//              (present only when CNT2BCD_BLANK_EN is defined)
//   Modports: master (requester side), slave (converter side).
// -----------------------------------------------------------------------------
interface cnt2bcd_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
);

  logic                  start_i;
  logic [IN_W-1:0]       bin_i;
  logic                  busy_o;
  logic                  done_o;
  logic [4*DIGITS-1:0]   bcd_o;
`ifdef CNT2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_o;
`endif

  modport master (
    output start_i,
    output bin_i,
    input  busy_o,
    input  done_o,
`ifdef CNT2BCD_BLANK_EN
    input  blank_o,
`endif
    input  bcd_o
  );

  modport slave (
    input  start_i,
    input  bin_i,
    output busy_o,
    output done_o,
`ifdef CNT2BCD_BLANK_EN
    output blank_o,
`endif
    output bcd_o
  );

endinterface

// File: rtl/cnt2bcd_bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//   Combinational shift-and-add-3 digit correction: a digit of 5..9 gets 3
//   added so that the following left shift carries correctly into the next
//   decimal digit. No carry leaves the 4-bit digit.
//   Ports:
//     dig_i  in   4  scratch BCD digit before correction
//     dig_o  out  4  corrected digit
// -----------------------------------------------------------------------------
module bcd_add3
  import cnt2bcd_pkg::*;
(
  input  bcd_digit_t dig_i,
  output bcd_digit_t dig_o
);

  assign dig_o = (dig_i >= BCD_ADD_THRESH) ? dig_i + BCD_ADD_VAL : dig_i;

endmodule

// File: rtl/cnt2bcd.sv
// -----------------------------------------------------------------------------
// cnt2bcd
//   Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
//   clock. A start in IDLE captures bin_i; IN_W cycles later the packed BCD
//   result is registered onto bcd_o with a 1-cycle done_o pulse. The result
//   holds until the next conversion completes. Starts while busy are ignored.
//
//   Parameters:
//     IN_W    binary input width
//     DIGITS  BCD output digits (must satisfy DIGITS >= IN_W*301/1000+1)
//
//   Ports:
//     clk_100MHz_i  in   system clock, rising edge
//     rst_i         in   asynchronous active-high reset
//     bus           slave modport of cnt2bcd_if (start_i, bin_i, busy_o,
//                   done_o, bcd_o, and blank_o when enabled)
//
//   Build option:
//     CNT2BCD_BLANK_EN  when defined, blank_o[i] (i>=1) flags digit i and all
//                       higher digits as zero; blank_o[0] is always 0. The
//                       mask is registered together with bcd_o.
// -----------------------------------------------------------------------------
module cnt2bcd
  import cnt2bcd_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input  logic       clk_100MHz_i,
  input  logic       rst_i,
  cnt2bcd_if.slave   bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int CAT_W = BCD_W + IN_W;

  // Too few digits would let the scratch register overflow silently.
  generate
    if (DIGITS < (IN_W * 301) / 1000 + 1) begin : g_digits_chk
      $error("cnt2bcd: DIGITS too small for IN_W");
    end
  endgenerate

  cnt2bcd_state_t     state_q, state_d;
  logic [IN_W-1:0]    bin_q,   bin_d;
  logic [BCD_W-1:0]   scr_q,   scr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic               done_q,  done_d;
`ifdef CNT2BCD_BLANK_EN
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic [DIGITS-1:0]  blank_nxt;
  logic               upper_zero;
`endif

  // Per-digit add-3 correction of the current scratch value.
  logic [BCD_W-1:0]   scr_add3;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
        .dig_i (scr_q[4*g +: 4]),
        .dig_o (scr_add3[4*g +: 4])
      );
    end
  endgenerate

  // One conversion step: shift {corrected scratch, binary} left by one, so
  // the binary MSB enters the scratch LSB. The shifted-out top bit is zero
  // whenever DIGITS is large enough.
  logic [CAT_W-1:0]   cat_shift;
  logic [BCD_W-1:0]   scr_shift;
  logic [IN_W-1:0]    bin_shift;

  assign cat_shift = {scr_add3, bin_q} << 1;
  assign scr_shift = cat_shift[CAT_W-1:IN_W];
  assign bin_shift = cat_shift[IN_W-1:0];

`ifdef CNT2BCD_BLANK_EN
  // Walk from the most significant digit down; a digit is blanked while
  // everything above it (and itself) is still zero. Digit 0 always shows.
  always_comb begin
    blank_nxt  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero & (scr_shift[4*i +: 4] == 4'd0);
      blank_nxt[i] = upper_zero;
    end
  end
`endif

  // FSM next-state and datapath next values.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
`ifdef CNT2BCD_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = CONV;
          bin_d   = bus.bin_i;
          scr_d   = '0;
          cnt_d   = CNT_W'(IN_W);
        end
      end
      CONV: begin
        bin_d = bin_shift;
        scr_d = scr_shift;
        cnt_d = cnt_q - CNT_W'(1);
        // Last bit: publish the finished scratch straight from the shifter.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          bcd_d   = scr_shift;
          done_d  = 1'b1;
`ifdef CNT2BCD_BLANK_EN
          blank_d = blank_nxt;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
`ifdef CNT2BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
`ifdef CNT2BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign bus.busy_o  = (state_q == CONV);
  assign bus.done_o  = done_q;
  assign bus.bcd_o   = bcd_q;
`ifdef CNT2BCD_BLANK_EN
  assign bus.blank_o = blank_q;
`endif

endmodule

// File: tb/tb_cnt2bcd.sv
// -----------------------------------------------------------------------------
// tb_cnt2bcd
//   Scoreboard bench for cnt2bcd. The stimulus side decides, from its own
//   model of when the converter is free, which starts are accepted and pushes
//   the expected decimal result and completion cycle. A monitor on the falling
//   edge checks busy_o, done_o timing, bcd_o (and blank_o when
//   CNT2BCD_BLANK_EN is defined) against the queue.
// -----------------------------------------------------------------------------
module tb_cnt2bcd;

  localparam int IN_W   = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W  = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cnt2bcd_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  cnt2bcd #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk_100MHz_i (clk),
    .rst_i        (rst),
    .bus          (bus.slave)
  );

  typedef struct {
    logic [BCD_W-1:0]  bcd;
    logic [DIGITS-1:0] blank;
    int                done_cyc;
  } exp_t;

  exp_t             q[$];
  int               n_chk = 0;
  int               n_pass = 0;
  int               cyc = 0;
  int               model_done_cyc = -1;
  logic [BCD_W-1:0] held_bcd = '0;
  bit               mon_en = 1'b0;
  bit               exp_busy;
  exp_t             e;

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits by plain division.
  function automatic logic [BCD_W-1:0] ref_bcd(input logic [IN_W-1:0] v);
    int unsigned x;
    logic [BCD_W-1:0] r;
    x = v;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit i (i>=1) blank iff the value has at most i decimal digits.
  function automatic logic [DIGITS-1:0] ref_blank(input logic [IN_W-1:0] v);
    int unsigned p;
    logic [DIGITS-1:0] b;
    p = 10;
    b = '0;
    for (int i = 1; i < DIGITS; i++) begin
      b[i] = (int'(v) < int'(p));
      p = p * 10;
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle of inputs; a start is accepted when the sampling edge
  // comes after the last predicted completion edge.
  task automatic step(input logic s, input logic [IN_W-1:0] b);
    bus.start_i = s;
    bus.bin_i   = b;
    if (s && (cyc + 1 > model_done_cyc)) begin
      q.push_back('{ref_bcd(b), ref_blank(b), cyc + 1 + IN_W});
      model_done_cyc = cyc + 1 + IN_W;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      exp_busy = 1'b0;
      foreach (q[i])
        if (cyc >= q[i].done_cyc - IN_W && cyc < q[i].done_cyc) exp_busy = 1'b1;
      check("busy", 32'(bus.busy_o), 32'(exp_busy));

      if (q.size() > 0 && q[0].done_cyc < cyc) begin
        n_chk++;
        $display("FAIL done_missing: no done_o by cycle %0d, required at %0d", cyc, q[0].done_cyc);
        void'(q.pop_front());
      end

      if (bus.done_o) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL done_spurious: done_o=1 at cycle %0d, required 0", cyc);
        end else begin
          e = q.pop_front();
          check("done_time", 32'(cyc), 32'(e.done_cyc));
          check("bcd", 32'(bus.bcd_o), 32'(e.bcd));
`ifdef CNT2BCD_BLANK_EN
          check("blank", 32'(bus.blank_o), 32'(e.blank));
`endif
          held_bcd = e.bcd;
        end
      end else begin
        check("bcd_hold", 32'(bus.bcd_o), 32'(held_bcd));
      end
    end
  end

  initial begin
    bus.start_i = 1'b0;
    bus.bin_i   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_bcd",  32'(bus.bcd_o),  32'd0);
`ifdef CNT2BCD_BLANK_EN
    check("rst_blank", 32'(bus.blank_o), 32'd0);
`endif
    rst = 1'b0;
    mon_en = 1'b1;

    // All-ones input.
    step(1'b1, 16'hFFFF);
    repeat (20) step(1'b0, 16'hFFFF);

    // Zero.
    step(1'b1, 16'd0);
    repeat (18) step(1'b0, 16'd0);

    // Start held for 5 cycles: only the first is accepted.
    repeat (5) step(1'b1, 16'd1234);
    repeat (14) step(1'b0, 16'd0);

    // Back-to-back: second start lands in the done cycle.
    step(1'b1, 16'd9999);
    repeat (16) step(1'b0, 16'd0);
    step(1'b1, 16'd10000);
    repeat (18) step(1'b0, 16'd0);

    // Reset in the middle of a conversion.
    step(1'b1, 16'd500);
    repeat (8) step(1'b0, 16'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_done", 32'(bus.done_o), 32'd0);
    check("abort_bcd",  32'(bus.bcd_o),  32'd0);
`ifdef CNT2BCD_BLANK_EN
    check("abort_blank", 32'(bus.blank_o), 32'd0);
`endif
    q.delete();
    held_bcd = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_done_cyc = cyc;
    repeat (20) step(1'b0, 16'd0);

    // Input churn while busy has no effect.
    step(1'b1, 16'd42);
    repeat (16) step(1'b0, 16'($urandom_range(0, 65535)));
    repeat (3) step(1'b0, 16'd0);

    // Random traffic, including starts while busy.
    repeat (600) step($urandom_range(0, 3) == 0, 16'($urandom_range(0, 65535)));

    repeat (IN_W + 3) step(1'b0, 16'd0);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
